// File: rtl/step_dir_pkg.sv
// Shared definitions for the STEP/DIR output shaper: state encoding and default timing width.
package step_dir_pkg;

    localparam int TW_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Phase counter: loads 1 on phase entry, counts up, and reports done once count >= live T.
// A count that starts at 1 makes T=0 and T=1 both give a one-cycle phase.
module phase_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          run,
    input  logic [TW-1:0] t,
    output logic          done
);

    logic [TW-1:0] cnt_q, cnt_d;

    assign done = (cnt_q >= t);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TW'(1);
        end else if (!run) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/step_dir_out.sv
// STEP/DIR pulse shaper enforcing DIR setup, STEP high and STEP low times (in clock cycles).
// Define STEP_DIR_OUT_QUEUE_EN to buffer one request while busy; otherwise busy requests drop.
module step_dir_out
    import step_dir_pkg::*;
#(
    parameter int TW = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stb,
    input  logic          dir,
    input  logic [TW-1:0] t_dir_setup,
    input  logic [TW-1:0] t_high,
    input  logic [TW-1:0] t_low,
    input  logic          clear_overrun,
    output logic          step,
    output logic          dir_out,
    output logic          busy,
    output logic          overrun
);

    state_t        state_q, state_d;
    logic          step_q, step_d;
    logic          dir_out_q, dir_out_d;
    logic          overrun_q, overrun_d;
    logic          load, run, phase_done;
    logic          start_req, start_dir, stb_taken, drop;
    logic [TW-1:0] t_sel;
`ifdef STEP_DIR_OUT_QUEUE_EN
    logic          pend_q, pend_d;
    logic          pend_dir_q, pend_dir_d;
`endif

    always_comb begin
        case (state_q)
            S_SETUP: t_sel = t_dir_setup;
            S_HIGH:  t_sel = t_high;
            default: t_sel = t_low;
        endcase
    end

    phase_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .run   (run),
        .t     (t_sel),
        .done  (phase_done)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        dir_out_d  = dir_out_q;
        overrun_d  = overrun_q;
        load       = 1'b0;
        start_req  = 1'b0;
        start_dir  = dir;
        stb_taken  = 1'b0;
        drop       = 1'b0;
`ifdef STEP_DIR_OUT_QUEUE_EN
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (stb) begin
                    start_req = 1'b1;
                    stb_taken = 1'b1;
                end
            end
            S_SETUP: begin
                if (phase_done) begin
                    step_d  = 1'b1;
                    state_d = S_HIGH;
                    load    = 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_done) begin
                    step_d  = 1'b0;
                    state_d = S_LOW;
                    load    = 1'b1;
                end
            end
            default: begin
                // Low-time expiry is also a start opportunity, so back-to-back requests see no idle gap.
                if (phase_done) begin
`ifdef STEP_DIR_OUT_QUEUE_EN
                    if (pend_q) begin
                        start_req = 1'b1;
                        start_dir = pend_dir_q;
                        pend_d    = 1'b0;
                    end else
`endif
                    if (stb) begin
                        start_req = 1'b1;
                        stb_taken = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        if (start_req) begin
            load = 1'b1;
            if (start_dir != dir_out_q) begin
                dir_out_d = start_dir;
                state_d   = S_SETUP;
            end else begin
                step_d  = 1'b1;
                state_d = S_HIGH;
            end
        end

        if (stb && !stb_taken) begin
`ifdef STEP_DIR_OUT_QUEUE_EN
            if (!pend_d) begin
                pend_d     = 1'b1;
                pend_dir_d = dir;
            end else begin
                drop = 1'b1;
            end
`else
            drop = 1'b1;
`endif
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        run = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            step_q     <= 1'b0;
            dir_out_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef STEP_DIR_OUT_QUEUE_EN
            pend_q     <= 1'b0;
            pend_dir_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            dir_out_q  <= dir_out_d;
            overrun_q  <= overrun_d;
`ifdef STEP_DIR_OUT_QUEUE_EN
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
`endif
        end
    end

    assign step    = step_q;
    assign dir_out = dir_out_q;
    assign overrun = overrun_q;
`ifdef STEP_DIR_OUT_QUEUE_EN
    assign busy    = (state_q != S_IDLE) || pend_q;
`else
    assign busy    = (state_q != S_IDLE);
`endif

endmodule
